count_wrap_tracker: RTL and testbench
=====================================

Name: count_wrap_tracker

Overview:
- Sits directly downstream of the 4-bit enable-driven free-running counter and consumes its count value.
- Detects counter wrap-around (max -> 0) and keeps a saturating wrap tally.
- Raises a sticky alarm after a programmable number of wraps.
- Serves on-demand snapshots of {count, wraps} over a valid/ready handshake to a consumer such as a status/CSR stage.

Parameters:
- CW, 4, width of the upstream count value.
- WRAP_W, 8, width of the wrap tally.
- ALARM_WRAPS, 16, wrap tally value at which alarm sets; legal range 1..2^WRAP_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cnt_value  in  CW  upstream counter value, sampled every cycle
- cnt_clear  in  1  copy of the upstream counter's reset; high = counter forced to 0 this edge
- snap_req  in  1  single-cycle snapshot request
- snap_valid  out  1  snapshot available
- snap_ready  in  1  consumer accepts snapshot
- snap_count  out  CW  captured cnt_value
- snap_wraps  out  WRAP_W  captured wrap_count
- wrap_pulse  out  1  one-cycle pulse per detected wrap
- wrap_count  out  WRAP_W  saturating wrap tally
- alarm  out  1  sticky, wrap_count reached ALARM_WRAPS
- dropped  out  1  one-cycle pulse, snap_req discarded while busy

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high):
  - All outputs 0; snap FSM in IDLE; prev_vld=0; prev_value=0; prev_clear=0.
  - Reset mid-handshake discards the pending snapshot.
- History registers, loaded every non-reset cycle:
  - prev_value<=cnt_value
  - prev_clear<=cnt_clear
  - prev_vld<=1
- Wrap detect (combinational, cycle t): wrap_det = prev_vld & ~prev_clear & (prev_value==2^CW-1) & (cnt_value==0).
  - A value jump to 0 from max caused by an upstream reset is never a wrap.
- Counter update at the edge ending cycle t, in priority order:
  1. cnt_clear=1 -> wrap_count<=0, alarm<=0, wrap_pulse<=0 (clear beats a same-cycle wrap).
  2. Else if wrap_det -> wrap_pulse<=1; wrap_count<=wrap_count+1, saturating at 2^WRAP_W-1 (pulse still fires at saturation).
  3. Else wrap_pulse<=0.
  - Latency: wrap visible on wrap_pulse/wrap_count 1 cycle after cnt_value shows 0.
- Alarm:
  - Sets at the edge where the next wrap_count value equals ALARM_WRAPS.
  - Remains set through saturation; cleared only by reset or cnt_clear.
- Snapshot FSM, states IDLE, VALID:
  - IDLE, snap_req=1: snap_count<=cnt_value, snap_wraps<=wrap_count (register value before any same-edge update), snap_valid<=1, go VALID. Latency 1 cycle.
  - VALID: snap_count and snap_wraps held stable; snap_valid stays 1 until handshake.
  - VALID, snap_valid & snap_ready & ~snap_req -> snap_valid<=0, go IDLE.
  - VALID, handshake & snap_req same cycle -> recapture, stay VALID (back-to-back, no bubble).
  - VALID, snap_req & ~snap_ready -> request discarded; dropped<=1 for one cycle; held data unchanged.
  - snap_ready while IDLE is ignored.
- cnt_clear does not affect the snapshot FSM or held snapshot data.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- Reset then 20 enable cycles from 0: cnt_value 15->0 at cycle 16 -> wrap_pulse=1 exactly at cycle 17; wrap_count=1; alarm=0.
- cnt_clear asserted while cnt_value=15, next cnt_value=0 -> no wrap_pulse; wrap_count=0.
- ALARM_WRAPS=2, WRAP_W=2, drive 5 wraps:
  - wrap_count sequence 1,2,3,3,3.
  - alarm sets on the edge wrap_count becomes 2 and stays 1.
  - wrap_pulse fires 5 times.
  - cnt_clear then -> wrap_count=0, alarm=0.
- snap_req with cnt_value=9, wrap_count=4, snap_ready=0 for 3 cycles:
  - snap_valid=1 next cycle with 9/4, stable through the stall.
  - A second snap_req during the stall -> dropped=1 one cycle; data still 9/4.
  - snap_ready=1 -> snap_valid=0 next cycle.
- Handshake cycle with simultaneous snap_req, cnt_value=3 -> snap_valid stays 1; snap_count=3 next cycle; no dropped pulse.
- Reset asserted while snap_valid=1 and wrap_count=7 -> next cycle all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/count_wrap_tracker.sv
// Watches an upstream free-running counter, tallies max->0 wraps, raises a sticky
// alarm after a programmable wrap count, and serves {count, wraps} snapshots.
module count_wrap_tracker #(
    parameter int unsigned CW          = 4,
    parameter int unsigned WRAP_W      = 8,
    parameter int unsigned ALARM_WRAPS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     cnt_value,
    input  logic              cnt_clear,
    input  logic              snap_req,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic [CW-1:0]     snap_count,
    output logic [WRAP_W-1:0] snap_wraps,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              alarm,
    output logic              dropped
);

    localparam logic [CW-1:0]     CNT_MAX  = {CW{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] ALARM_AT = WRAP_W'(ALARM_WRAPS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } snap_state_e;

    logic [CW-1:0]     prev_value_q, prev_value_d;
    logic              prev_clear_q, prev_clear_d;
    logic              prev_vld_q,   prev_vld_d;

    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              alarm_q,      alarm_d;

    snap_state_e       state_q, state_d;
    logic              snap_valid_q, snap_valid_d;
    logic [CW-1:0]     snap_count_q, snap_count_d;
    logic [WRAP_W-1:0] snap_wraps_q, snap_wraps_d;
    logic              dropped_q,    dropped_d;

    logic              wrap_det_c;

    // History of the previous upstream sample
    always_comb begin
        prev_value_d = cnt_value;
        prev_clear_d = cnt_clear;
        prev_vld_d   = 1'b1;
    end

    // A max->0 step only counts if the upstream was not being cleared last cycle
    assign wrap_det_c = prev_vld_q & ~prev_clear_q & (prev_value_q == CNT_MAX)
                      & (cnt_value == '0);

    // Wrap tally and alarm; an upstream clear wins over a same-cycle wrap
    always_comb begin
        wrap_count_d = wrap_count_q;
        alarm_d      = alarm_q;
        wrap_pulse_d = 1'b0;
        if (cnt_clear) begin
            wrap_count_d = '0;
            alarm_d      = 1'b0;
        end else if (wrap_det_c) begin
            wrap_pulse_d = 1'b1;
            if (wrap_count_q != WRAP_MAX) begin
                wrap_count_d = wrap_count_q + WRAP_W'(1);
            end
            if (wrap_count_d == ALARM_AT) begin
                alarm_d = 1'b1;
            end
        end
    end

    // Snapshot FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (snap_ready && !snap_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Snapshot outputs: capture on a fresh request or a request riding a handshake
    always_comb begin
        snap_valid_d = (state_d == S_VALID);
        snap_count_d = snap_count_q;
        snap_wraps_d = snap_wraps_q;
        dropped_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    snap_count_d = cnt_value;
                    snap_wraps_d = wrap_count_q;
                end
            end
            S_VALID: begin
                if (snap_req && snap_ready) begin
                    snap_count_d = cnt_value;
                    snap_wraps_d = wrap_count_q;
                end else if (snap_req) begin
                    dropped_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_value_q <= '0;
            prev_clear_q <= 1'b0;
            prev_vld_q   <= 1'b0;
            wrap_count_q <= '0;
            wrap_pulse_q <= 1'b0;
            alarm_q      <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
            snap_wraps_q <= '0;
            dropped_q    <= 1'b0;
        end else begin
            prev_value_q <= prev_value_d;
            prev_clear_q <= prev_clear_d;
            prev_vld_q   <= prev_vld_d;
            wrap_count_q <= wrap_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            alarm_q      <= alarm_d;
            snap_valid_q <= snap_valid_d;
            snap_count_q <= snap_count_d;
            snap_wraps_q <= snap_wraps_d;
            dropped_q    <= dropped_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_count = snap_count_q;
    assign snap_wraps = snap_wraps_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign alarm      = alarm_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Bench for count_wrap_tracker: two instances (default and narrow tally) share
// stimulus and are checked each cycle against a behavioural model.
module tb_count_wrap_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_value = '0;
    logic       cnt_clear = 1'b0;
    logic       snap_req = 1'b0;
    logic       snap_ready = 1'b0;

    logic       sv_a, wp_a, al_a, dr_a;
    logic [3:0] sc_a;
    logic [7:0] sw_a, wc_a;
    logic       sv_b, wp_b, al_b, dr_b;
    logic [3:0] sc_b;
    logic [1:0] sw_b, wc_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    count_wrap_tracker #(.CW(4), .WRAP_W(8), .ALARM_WRAPS(16)) dut_a (
        .clk(clk), .reset(reset), .cnt_value(cnt_value), .cnt_clear(cnt_clear),
        .snap_req(snap_req), .snap_valid(sv_a), .snap_ready(snap_ready),
        .snap_count(sc_a), .snap_wraps(sw_a), .wrap_pulse(wp_a),
        .wrap_count(wc_a), .alarm(al_a), .dropped(dr_a)
    );

    count_wrap_tracker #(.CW(4), .WRAP_W(2), .ALARM_WRAPS(2)) dut_b (
        .clk(clk), .reset(reset), .cnt_value(cnt_value), .cnt_clear(cnt_clear),
        .snap_req(snap_req), .snap_valid(sv_b), .snap_ready(snap_ready),
        .snap_count(sc_b), .snap_wraps(sw_b), .wrap_pulse(wp_b),
        .wrap_count(wc_b), .alarm(al_b), .dropped(dr_b)
    );

    // Reference model: unbounded wrap count since last clear, reported saturated
    int   wmax [2] = '{255, 3};
    int   alm  [2] = '{16, 2};
    int   m_wraps [2];
    bit   m_pulse [2];
    bit   m_pend  [2];
    int   m_sc    [2];
    int   m_sw    [2];
    bit   m_drop  [2];
    int   h_val;
    bit   h_clr;
    bit   h_vld;
    bit   m_live = 1'b0;

    function automatic int sat_wc(input int i);
        return (m_wraps[i] > wmax[i]) ? wmax[i] : m_wraps[i];
    endfunction

    always @(posedge clk) begin
        bit is_wrap;
        int before_wc;
        if (reset) begin
            m_live = 1'b1;
            h_val = 0; h_clr = 1'b0; h_vld = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_wraps[i] = 0; m_pulse[i] = 1'b0; m_pend[i] = 1'b0;
                m_sc[i] = 0; m_sw[i] = 0; m_drop[i] = 1'b0;
            end
        end else begin
            is_wrap = h_vld && !h_clr && (h_val == 15) && (int'(cnt_value) == 0);
            for (int i = 0; i < 2; i++) begin
                before_wc = sat_wc(i);
                if (cnt_clear) begin
                    m_wraps[i] = 0; m_pulse[i] = 1'b0;
                end else if (is_wrap) begin
                    if (m_wraps[i] < 100000) m_wraps[i]++;
                    m_pulse[i] = 1'b1;
                end else begin
                    m_pulse[i] = 1'b0;
                end
                m_drop[i] = 1'b0;
                if (snap_req && (!m_pend[i] || snap_ready)) begin
                    m_pend[i] = 1'b1; m_sc[i] = int'(cnt_value); m_sw[i] = before_wc;
                end else if (m_pend[i] && snap_ready) begin
                    m_pend[i] = 1'b0;
                end else if (m_pend[i] && snap_req) begin
                    m_drop[i] = 1'b1;
                end
            end
            h_val = int'(cnt_value); h_clr = cnt_clear; h_vld = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total_cnt++;
        if (act === 32'(exp)) pass_cnt++;
        else $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    endtask

    task automatic cmp_inst(input int i, input string n, input logic sv, input logic [3:0] sc,
                            input logic [7:0] sw, input logic wp, input logic [7:0] wc,
                            input logic al, input logic dr);
        chk({n, ".snap_valid"}, 32'(sv), int'(m_pend[i]));
        chk({n, ".snap_count"}, 32'(sc), m_sc[i]);
        chk({n, ".snap_wraps"}, 32'(sw), m_sw[i]);
        chk({n, ".wrap_pulse"}, 32'(wp), int'(m_pulse[i]));
        chk({n, ".wrap_count"}, 32'(wc), sat_wc(i));
        chk({n, ".alarm"},      32'(al), (m_wraps[i] >= alm[i]) ? 1 : 0);
        chk({n, ".dropped"},    32'(dr), int'(m_drop[i]));
    endtask

    // Per-cycle comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (m_live) begin
            cmp_inst(0, "a", sv_a, sc_a, sw_a, wp_a, wc_a, al_a, dr_a);
            cmp_inst(1, "b", sv_b, sc_b, 8'(sw_b), wp_b, 8'(wc_b), al_b, dr_b);
        end
    end

    // Inputs change on the falling edge and hold for one full cycle
    task automatic drive(input logic r, input int v, input logic c, input logic q, input logic y);
        reset = r; cnt_value = 4'(v); cnt_clear = c; snap_req = q; snap_ready = y;
        @(negedge clk);
    endtask

    task automatic one_wrap(input logic q, input logic y);
        drive(1'b0, 15, 1'b0, q, y);
        drive(1'b0, 0, 1'b0, q, y);
    endtask

    initial begin
        int seq [5];
        int ctr;
        int r;
        seq = '{1, 2, 3, 3, 3};

        @(negedge clk);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("rst_wrap_count", 32'(wc_a), 0);
        chk("rst_snap_valid", 32'(sv_a), 0);

        // Free-running count from 0: 15->0 at cycle 16 shows up one cycle later
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, k % 16, 1'b0, 1'b0, 1'b0);
            if (k == 15) chk("pulse_before_wrap", 32'(wp_a), 0);
            if (k == 16) begin
                chk("pulse_at_17", 32'(wp_a), 1);
                chk("count_at_17", 32'(wc_a), 1);
                chk("alarm_at_17", 32'(al_a), 0);
                chk("model_wraps_at_17", 32'(m_wraps[0]), 1);
            end
            if (k == 17) chk("pulse_one_cycle", 32'(wp_a), 0);
        end

        // Upstream clear at 15 then 0 is not a wrap
        drive(1'b0, 15, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("clr_no_pulse", 32'(wp_a), 0);
        chk("clr_count", 32'(wc_a), 0);

        // Narrow instance: saturation and sticky alarm
        for (int j = 0; j < 5; j++) begin
            one_wrap(1'b0, 1'b0);
            chk("sat_count_b", 32'(wc_b), seq[j]);
            chk("sat_alarm_b", 32'(al_b), (j >= 1) ? 1 : 0);
            chk("sat_pulse_b", 32'(wp_b), 1);
        end
        drive(1'b0, 7, 1'b1, 1'b0, 1'b0);
        chk("clr_count_b", 32'(wc_b), 0);
        chk("clr_alarm_b", 32'(al_b), 0);

        // Snapshot with stall, dropped request, then handshake
        repeat (4) one_wrap(1'b0, 1'b0);
        chk("pre_snap_wc", 32'(wc_a), 4);
        drive(1'b0, 9, 1'b0, 1'b1, 1'b0);
        chk("snap_valid", 32'(sv_a), 1);
        chk("snap_count", 32'(sc_a), 9);
        chk("snap_wraps", 32'(sw_a), 4);
        drive(1'b0, 9, 1'b0, 1'b0, 1'b0);
        chk("stall_count", 32'(sc_a), 9);
        drive(1'b0, 2, 1'b0, 1'b1, 1'b0);
        chk("drop_pulse", 32'(dr_a), 1);
        chk("drop_count", 32'(sc_a), 9);
        chk("drop_wraps", 32'(sw_a), 4);
        drive(1'b0, 9, 1'b0, 1'b0, 1'b0);
        chk("drop_one_cycle", 32'(dr_a), 0);
        chk("stall_valid", 32'(sv_a), 1);
        drive(1'b0, 9, 1'b0, 1'b0, 1'b1);
        chk("hs_valid_low", 32'(sv_a), 0);

        // Back-to-back recapture on the handshake cycle
        drive(1'b0, 5, 1'b0, 1'b1, 1'b0);
        chk("b2b_first", 32'(sc_a), 5);
        drive(1'b0, 3, 1'b0, 1'b1, 1'b1);
        chk("b2b_valid", 32'(sv_a), 1);
        chk("b2b_count", 32'(sc_a), 3);
        chk("b2b_no_drop", 32'(dr_a), 0);

        // Reset mid-handshake with a non-zero tally
        repeat (3) one_wrap(1'b0, 1'b0);
        chk("pre_rst_wc", 32'(wc_a), 7);
        chk("pre_rst_valid", 32'(sv_a), 1);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(sv_a), 0);
        chk("rst_wc", 32'(wc_a), 0);
        chk("rst_sc", 32'(sc_a), 0);
        chk("rst_sw", 32'(sw_a), 0);
        chk("rst_pulse", 32'(wp_a), 0);
        chk("rst_alarm", 32'(al_a), 0);
        chk("rst_drop", 32'(dr_a), 0);

        // Randomized counter-like traffic with jumps, clears, resets and handshakes
        ctr = 0;
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 30) ctr = int'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) != 0) ctr = (ctr + 1) % 16;
            drive(($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0, ctr,
                  ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
